// File: rtl/prog_sequencer.sv
// Instruction sequencer: replays a loaded program buffer to the processor
// over its Run/Done handshake, halting after Len instructions or on timeout.
module prog_sequencer #(
  parameter int unsigned AW      = 5,
  parameter int unsigned TIMEOUT = 7
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          WrEn,
  input  logic [AW-1:0] WrAddr,
  input  logic [15:0]   WrData,
  input  logic          Start,
  input  logic [AW:0]   Len,
  input  logic          Done,
  output logic [15:0]   DIN,
  output logic          Run,
  output logic          Busy,
  output logic          Halted,
  output logic          Err,
  output logic [AW-1:0] PC
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned DW    = 16;
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned TW    = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HALT,
    S_ERR
  } state_t;

  state_t        state;
  logic [DW-1:0] mem [DEPTH];
  logic [CW-1:0] len_q;
  logic [CW-1:0] cnt_q;
  logic [TW-1:0] tmo_q;

  logic          wr_ok_c;
  logic [AW-1:0] pc_next_c;
  logic [CW-1:0] cnt_next_c;
  logic [TW-1:0] tmo_next_c;
  logic [DW-1:0] first_word_c;

  assign wr_ok_c      = WrEn && (state == S_IDLE || state == S_HALT || state == S_ERR);
  assign pc_next_c    = PC + AW'(1);
  assign cnt_next_c   = cnt_q + CW'(1);
  assign tmo_next_c   = tmo_q + TW'(1);
  // A write landing on the Start edge must be seen by the first issue.
  assign first_word_c = (wr_ok_c && WrAddr == '0) ? WrData : mem[0];

  always_ff @(posedge Clock) begin
    if (wr_ok_c) mem[WrAddr] <= WrData;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state  <= S_IDLE;
      DIN    <= '0;
      Run    <= 1'b0;
      Busy   <= 1'b0;
      Halted <= 1'b0;
      Err    <= 1'b0;
      PC     <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      tmo_q  <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT, S_ERR: begin
          if (Start) begin
            len_q  <= Len;
            PC     <= '0;
            cnt_q  <= '0;
            Err    <= 1'b0;
            if (Len == '0) begin
              state  <= S_HALT;
              Halted <= 1'b1;
            end else begin
              state  <= S_ISSUE;
              Halted <= 1'b0;
              Run    <= 1'b1;
              Busy   <= 1'b1;
              DIN    <= first_word_c;
            end
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
          Run   <= 1'b0;
          DIN   <= '0;
          tmo_q <= '0;
        end
        S_WAIT: begin
          if (Done) begin
            PC    <= pc_next_c;
            cnt_q <= cnt_next_c;
            if (cnt_next_c == len_q) begin
              state  <= S_HALT;
              Halted <= 1'b1;
              Busy   <= 1'b0;
            end else begin
              state <= S_ISSUE;
              Run   <= 1'b1;
              DIN   <= mem[pc_next_c];
            end
          end else begin
            tmo_q <= tmo_next_c;
            // PC is left on the instruction that never completed.
            if (tmo_next_c == TW'(TIMEOUT)) begin
              state <= S_ERR;
              Err   <= 1'b1;
              Busy  <= 1'b0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench for prog_sequencer with a behavioural processor responder.
module tb_prog_sequencer;

  localparam int unsigned AW      = 5;
  localparam int unsigned TIMEOUT = 7;
  localparam int unsigned DEPTH   = 32;

  logic          Clock = 1'b0;
  logic          Resetn;
  logic          WrEn;
  logic [AW-1:0] WrAddr;
  logic [15:0]   WrData;
  logic          Start;
  logic [AW:0]   Len;
  logic          Done;
  logic [15:0]   DIN;
  logic          Run;
  logic          Busy;
  logic          Halted;
  logic          Err;
  logic [AW-1:0] PC;

  prog_sequencer #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .Clock(Clock), .Resetn(Resetn), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .Start(Start), .Len(Len), .Done(Done), .DIN(DIN), .Run(Run), .Busy(Busy),
    .Halted(Halted), .Err(Err), .PC(PC)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int          kind;  // 0 issue, 1 halt, 2 error
    int          pc;
    logic [15:0] din;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] ref_mem [DEPTH];
  logic [15:0] r [8];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_run = -10;
  int run_cnt  = 0;
  bit proc_en  = 1'b1;
  bit gap_chk  = 1'b0;
  bit start_acc = 1'b0;
  bit halted_prev = 1'b0;
  bit err_prev    = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic pop_cmp(input int kind, input int pc, input logic [15:0] din);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got kind %0d pc %0h with empty scoreboard", kind, pc);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_pc", pc, e.pc);
      if (kind == 0) chk("issue_din", int'(din), int'(e.din));
    end
  endtask

  initial forever begin
    @(posedge Clock);
    cyc++;
    start_acc = Start && !Busy && Resetn;
  end

  // Monitor: every observed issue/termination is matched against the queue.
  initial forever begin
    @(negedge Clock);
    if (Resetn) begin
      if (Run) begin
        chk("run_not_back_to_back", int'(cyc - last_run > 1), 1);
        if (gap_chk && last_run >= 0) chk("run_spacing", cyc - last_run, 2);
        last_run = cyc;
        run_cnt++;
        pop_cmp(0, int'(PC), DIN);
      end else begin
        chk("din_zero_outside_issue", int'(DIN), 0);
      end
      if (Halted && (!halted_prev || start_acc)) pop_cmp(1, int'(PC), 16'h0);
      if (Err && !err_prev) pop_cmp(2, int'(PC), 16'h0);
    end
    halted_prev = Halted;
    err_prev    = Err;
  end

  function automatic int latency(input logic [15:0] w);
    return (w[15:13] == 3'd2 || w[15:13] == 3'd3) ? 3 : 1;
  endfunction

  // Processor: Done in T1 for mv/mvt, in T3 for add/sub.
  initial begin
    int          wl;
    bit          run_s;
    logic [15:0] din_s;
    logic [15:0] opnd;
    Done = 1'b0;
    wl   = 0;
    for (int i = 0; i < 8; i++) r[i] = '0;
    forever begin
      @(posedge Clock or negedge Resetn);
      if (!Resetn) begin
        wl   = 0;
        Done = 1'b0;
        for (int i = 0; i < 8; i++) r[i] = '0;
      end else begin
        run_s = Run;
        din_s = DIN;
        #1;
        if (run_s && proc_en) begin
          wl   = latency(din_s);
          opnd = din_s[12] ? {7'd0, din_s[8:0]} : r[din_s[2:0]];
          case (din_s[15:13])
            3'd0:    r[din_s[11:9]] = opnd;
            3'd1:    r[din_s[11:9]] = {din_s[7:0], 8'h00};
            3'd2:    r[din_s[11:9]] = r[din_s[11:9]] + opnd;
            3'd3:    r[din_s[11:9]] = r[din_s[11:9]] - opnd;
            default: ;
          endcase
        end else if (wl > 0) begin
          wl--;
        end
        Done = (wl == 1) && Resetn;
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic write(input int a, input logic [15:0] d);
    WrEn = 1'b1; WrAddr = AW'(a); WrData = d;
    tick();
    WrEn = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic expect_run(input int len);
    for (int k = 0; k < len; k++) exp_q.push_back('{0, k % DEPTH, ref_mem[k % DEPTH]});
    exp_q.push_back('{1, len % DEPTH, 16'h0});
  endtask

  task automatic start(input int len);
    Len = (AW+1)'(len); Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((Busy || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    chk("sequence_finished_in_budget", int'(n < budget), 1);
  endtask

  function automatic logic [15:0] rnd_word();
    logic [2:0] op = 3'($urandom_range(0, 3));
    return {op, 1'b1, 3'($urandom_range(0, 7)), 9'($urandom_range(0, 511))};
  endfunction

  initial begin
    int n;
    WrEn = 0; WrAddr = '0; WrData = '0; Start = 0; Len = '0;
    Resetn = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    repeat (3) tick();
    chk("reset_din", int'(DIN), 0);
    chk("reset_run", int'(Run), 0);
    chk("reset_busy", int'(Busy), 0);
    chk("reset_halted", int'(Halted), 0);
    chk("reset_err", int'(Err), 0);
    chk("reset_pc", int'(PC), 0);
    Resetn = 1'b1;
    for (int i = 0; i < DEPTH; i++) write(i, 16'h1000);

    // mv r0,#5 ; add r0,#3 with exact cycle timing
    write(0, 16'h1005);
    write(1, 16'h5003);
    expect_run(2);
    start(2);
    for (int c = 1; c <= 8; c++) begin
      @(negedge Clock);
      chk($sformatf("t1_run_c%0d", c), int'(Run), int'(c == 1 || c == 3));
      chk($sformatf("t1_busy_c%0d", c), int'(Busy), int'(c >= 1 && c <= 6));
      chk($sformatf("t1_halted_c%0d", c), int'(Halted), int'(c >= 7));
    end
    wait_done(50);
    chk("t1_r0", int'(r[0]), 8);

    // Len=0 halts immediately without any issue
    exp_q.push_back('{1, 0, 16'h0});
    start(0);
    @(negedge Clock);
    chk("len0_halted", int'(Halted), 1);
    chk("len0_run", int'(Run), 0);
    chk("len0_pc", int'(PC), 0);
    chk("len0_busy", int'(Busy), 0);
    wait_done(10);

    // Processor never answers
    proc_en = 1'b0;
    exp_q.push_back('{0, 0, ref_mem[0]});
    exp_q.push_back('{2, 0, 16'h0});
    start(1);
    n = 1;
    while (!Err && n < 50) begin
      tick();
      n++;
    end
    chk("timeout_err_cycle", n, 2 + TIMEOUT);
    chk("timeout_busy", int'(Busy), 0);
    chk("timeout_pc", int'(PC), 0);
    wait_done(10);
    proc_en = 1'b1;

    // Asynchronous reset in the middle of an add's WAIT
    write(0, 16'h5003);
    exp_q.push_back('{0, 0, ref_mem[0]});
    start(1);
    tick();
    #2;
    Resetn = 1'b0;
    #1;
    chk("midrst_run", int'(Run), 0);
    chk("midrst_busy", int'(Busy), 0);
    chk("midrst_halted", int'(Halted), 0);
    chk("midrst_err", int'(Err), 0);
    chk("midrst_pc", int'(PC), 0);
    chk("midrst_din", int'(DIN), 0);
    exp_q.delete();
    tick();
    Resetn = 1'b1;
    tick();
    last_run = -10;
    expect_run(1);
    start(1);
    wait_done(30);
    chk("rerun_r0", int'(r[0]), 3);

    // Start and write while busy are both ignored
    write(0, 16'h5001);
    write(1, 16'h5002);
    write(2, 16'h5004);
    expect_run(3);
    start(3);
    tick();
    WrEn = 1'b1; WrAddr = AW'(1); WrData = 16'hFFFF; Len = (AW+1)'(1); Start = 1'b1;
    tick();
    WrEn = 1'b0; Start = 1'b0;
    wait_done(100);

    // Write and Start on the same edge: first issue sees the new word
    ref_mem[0] = 16'h1A5A;
    expect_run(1);
    WrEn = 1'b1; WrAddr = '0; WrData = 16'h1A5A; Len = (AW+1)'(1); Start = 1'b1;
    tick();
    WrEn = 1'b0; Start = 1'b0;
    wait_done(30);

    // Full buffer of mv instructions, PC wraps
    for (int k = 0; k < DEPTH; k++) write(k, {3'b000, 1'b1, 3'(k % 8), 9'(k)});
    last_run = -10;
    run_cnt  = 0;
    gap_chk  = 1'b1;
    expect_run(DEPTH);
    start(DEPTH);
    wait_done(200);
    gap_chk = 1'b0;
    chk("wrap_run_count", run_cnt, DEPTH);
    chk("wrap_pc", int'(PC), 0);
    chk("wrap_halted", int'(Halted), 1);

    // Randomized programs and lengths
    for (int it = 0; it < 20; it++) begin
      int len;
      n = $urandom_range(0, 4);
      for (int w = 0; w < n; w++) write($urandom_range(0, DEPTH - 1), rnd_word());
      len = $urandom_range(0, DEPTH);
      if ($urandom_range(0, 3) == 0) begin
        int a = $urandom_range(0, 2);
        logic [15:0] d = rnd_word();
        ref_mem[a] = d;
        expect_run(len);
        WrEn = 1'b1; WrAddr = AW'(a); WrData = d; Len = (AW+1)'(len); Start = 1'b1;
        tick();
        WrEn = 1'b0; Start = 1'b0;
      end else begin
        expect_run(len);
        start(len);
      end
      wait_done(400);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
